// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit core's fetch path.
// Includes opcode values, instruction field positions and the fetch FSM encoding.
package core_pkg;

    localparam logic [3:0] OP_RESET = 4'h0;
    localparam logic [3:0] OP_JEQ   = 4'h7;
    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_JR    = 4'hB;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int TGT_HI = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundles the fetch unit's instruction-memory bus and its decode-side handshake.
// The master modport is the fetch unit; the slave modport is memory plus decode.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [3:0]        out_opcode;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output out_valid, out_instr, out_opcode, out_pc,
        input  out_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  out_valid, out_instr, out_opcode, out_pc,
        output out_ready
    );

endinterface

// File: rtl/instr_fetch_unit_pc_next_sel.sv
// Next-PC priority mux: jr > jump > taken jeq > sequential.
// Jump targets are page-relative, so the top PC bits are kept and there is no carry.
module pc_next_sel
    import core_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [TGT_HI:0]   target,
    input  logic              jr,
    input  logic              jump,
    input  logic              jeq,
    input  logic              eq_flag,
    input  logic [ADDR_W-1:0] jr_addr,
    output logic [ADDR_W-1:0] next_pc,
    output logic              redirect
);

    logic [ADDR_W-1:0] page_target;

    assign page_target = {pc[ADDR_W-1:TGT_HI+1], target};

    always_comb begin
        // NOTE: defaults first, so every path assigns both outputs and no latch is inferred.
        next_pc  = pc + ADDR_W'(1);
        redirect = 1'b1;
        if (jr) begin
            next_pc = jr_addr;
        end else if (jump) begin
            next_pc = page_target;
        end else if (jeq && eq_flag) begin
            next_pc = page_target;
        end else begin
            redirect = 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: owns the PC, fetches one word at a time from instruction memory and holds it for decode.
// Defining IFU_REDIRECT_CNT_EN adds a saturating redirect_cnt output that counts taken redirects.
module instr_fetch_unit
    import core_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    instr_fetch_unit_if.master       bus,
    input  logic                     jump,
    input  logic                     jeq,
    input  logic                     jr,
    input  logic                     eq_flag,
`ifdef IFU_REDIRECT_CNT_EN
    output logic [15:0]              redirect_cnt,
`endif
    input  logic [ADDR_W-1:0]        jr_addr
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic              redirect;
    logic              handshake;

    assign handshake      = (state == HOLD) && bus.out_ready;
    assign bus.out_opcode = bus.out_instr[OPC_HI:OPC_LO];

    pc_next_sel #(.ADDR_W(ADDR_W)) u_pc_next_sel (
        .pc       (pc),
        .target   (bus.out_instr[TGT_HI:0]),
        .jr       (jr),
        .jump     (jump),
        .jeq      (jeq),
        .eq_flag  (eq_flag),
        .jr_addr  (jr_addr),
        .next_pc  (next_pc),
        .redirect (redirect)
    );

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            bus.imem_req  <= 1'b0;
            bus.imem_addr <= RESET_PC;
            bus.out_valid <= 1'b0;
            bus.out_instr <= {OP_RESET, {(DATA_W-4){1'b0}}};
            bus.out_pc    <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    state         <= REQ;
                    bus.imem_req  <= 1'b1;
                    bus.imem_addr <= pc;
                end
                REQ: begin
                    if (bus.imem_gnt) begin
                        state        <= WAIT;
                        bus.imem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        state         <= HOLD;
                        bus.out_instr <= bus.imem_rdata;
                        bus.out_pc    <= pc;
                        bus.out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    // Redirect inputs only matter here, on the decode handshake.
                    if (bus.out_ready) begin
                        state         <= REQ;
                        pc            <= next_pc;
                        bus.imem_req  <= 1'b1;
                        bus.imem_addr <= next_pc;
                        bus.out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IFU_REDIRECT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_cnt <= 16'h0000;
        end else if (handshake && redirect && (redirect_cnt != 16'hFFFF)) begin
            redirect_cnt <= redirect_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, jumps, jeq, priority, stall, wrap and async reset.
// The bench plays instruction memory and decode; all expected values are hand-derived constants.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump, jeq, jr, eq_flag;
    logic [15:0] jr_addr;
    int          total = 0;
    int          bad   = 0;
`ifdef IFU_REDIRECT_CNT_EN
    logic [15:0] redirect_cnt;
`endif

    instr_fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    instr_fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .jump         (jump),
        .jeq          (jeq),
        .jr           (jr),
        .eq_flag      (eq_flag),
`ifdef IFU_REDIRECT_CNT_EN
        .redirect_cnt (redirect_cnt),
`endif
        .jr_addr      (jr_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Acts as memory for one fetch: waits (bounded) for the request, grants, then returns data a cycle later.
    task automatic serve(input logic [15:0] addr, input logic [15:0] data, input string tag);
        int n = 0;
        while (!bus.imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " req"}, 32'(bus.imem_req), 32'd1);
        check({tag, " addr"}, 32'(bus.imem_addr), 32'(addr));
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        bus.imem_gnt = 1'b0;
        check({tag, " wait_req"}, 32'(bus.imem_req), 32'd0);
        check({tag, " wait_valid"}, 32'(bus.out_valid), 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = data;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 16'h0000;
        check({tag, " valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, " instr"}, 32'(bus.out_instr), 32'(data));
        check({tag, " pc"}, 32'(bus.out_pc), 32'(addr));
    endtask

    task automatic handshake(input logic jr_i, input logic jump_i, input logic jeq_i, input logic eq_i,
                             input logic [15:0] jra, input logic [15:0] exp_next, input string tag);
        jr = jr_i; jump = jump_i; jeq = jeq_i; eq_flag = eq_i; jr_addr = jra;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        jr = 1'b0; jump = 1'b0; jeq = 1'b0; eq_flag = 1'b0; jr_addr = 16'h0000;
        check({tag, " valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, " next_req"}, 32'(bus.imem_req), 32'd1);
        check({tag, " next_addr"}, 32'(bus.imem_addr), 32'(exp_next));
    endtask

    initial begin
        rst = 1'b1;
        jump = 1'b0; jeq = 1'b0; jr = 1'b0; eq_flag = 1'b0; jr_addr = 16'h0000;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 16'h0000;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst valid", 32'(bus.out_valid), 32'd0);
        check("rst req", 32'(bus.imem_req), 32'd0);
        check("rst addr", 32'(bus.imem_addr), 32'h0000);
        check("rst instr", 32'(bus.out_instr), 32'h0000);
        check("rst opcode", 32'(bus.out_opcode), 32'h0);
        check("rst pc", 32'(bus.out_pc), 32'h0000);
        rst = 1'b0;
        check("idle req", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        check("idle one cycle", 32'(bus.imem_req), 32'd1);

        // Sequential fetch from 0 and 1.
        serve(16'h0000, 16'h1123, "seq0");
        check("seq0 opcode", 32'(bus.out_opcode), 32'h1);
        handshake(0, 0, 0, 0, 16'h0000, 16'h0001, "seq0");
        serve(16'h0001, 16'h2456, "seq1");
        check("seq1 opcode", 32'(bus.out_opcode), 32'h2);
        handshake(0, 0, 0, 0, 16'h0000, 16'h0002, "seq1");

        // jr to 0x3005, then page-relative jump from there.
        serve(16'h0002, 16'hB000, "jr3005");
        handshake(1, 0, 0, 0, 16'h3005, 16'h3005, "jr3005");
        serve(16'h3005, 16'hA0F0, "jmp");
        check("jmp opcode", 32'(bus.out_opcode), 32'hA);
        handshake(0, 1, 0, 0, 16'h0000, 16'h30F0, "jmp");

        // Redirects asserted outside HOLD must be ignored.
        jr = 1'b1; jump = 1'b1; jr_addr = 16'h1234;
        serve(16'h30F0, 16'h0000, "ignore");
        handshake(0, 0, 0, 0, 16'h0000, 16'h30F1, "ignore");

        // jeq taken and not taken at pc 0x0010.
        serve(16'h30F1, 16'hB000, "jr0010a");
        handshake(1, 0, 0, 0, 16'h0010, 16'h0010, "jr0010a");
        serve(16'h0010, 16'h7040, "jeq_taken");
        handshake(0, 0, 1, 1, 16'h0000, 16'h0040, "jeq_taken");
        serve(16'h0040, 16'hB000, "jr0010b");
        handshake(1, 0, 0, 0, 16'h0010, 16'h0010, "jr0010b");
        serve(16'h0010, 16'h7040, "jeq_not");
        handshake(0, 0, 1, 0, 16'h0000, 16'h0011, "jeq_not");

        // All redirects at once: jr wins over the jump target 0x0123.
        serve(16'h0011, 16'hA123, "prio");
        handshake(1, 1, 1, 1, 16'hBEEF, 16'hBEEF, "prio");
        serve(16'hBEEF, 16'hB000, "jrffff");
        handshake(1, 0, 0, 0, 16'hFFFF, 16'hFFFF, "jrffff");

        // Stall in HOLD at 0xFFFF with stray gnt/rvalid, then wrap to 0.
        serve(16'hFFFF, 16'h5ABC, "stall");
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_gnt    = 1'b1;
                bus.imem_rdata  = 16'h1111;
            end
            @(negedge clk);
            bus.imem_rvalid = 1'b0;
            bus.imem_gnt    = 1'b0;
            bus.imem_rdata  = 16'h0000;
            check($sformatf("stall%0d valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("stall%0d instr", i), 32'(bus.out_instr), 32'h5ABC);
            check($sformatf("stall%0d req", i), 32'(bus.imem_req), 32'd0);
            check($sformatf("stall%0d pc", i), 32'(bus.out_pc), 32'hFFFF);
        end
        handshake(0, 0, 0, 0, 16'h0000, 16'h0000, "wrap");

        // Move off RESET_PC, then reset while waiting for the response.
        serve(16'h0000, 16'hB000, "jr0123");
        handshake(1, 0, 0, 0, 16'h0123, 16'h0123, "jr0123");
`ifdef IFU_REDIRECT_CNT_EN
        check("redirect_cnt", 32'(redirect_cnt), 32'd8);
`endif
        check("pre_rst addr", 32'(bus.imem_addr), 32'h0123);
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        bus.imem_gnt = 1'b0;
        check("pre_rst opcode", 32'(bus.out_opcode), 32'hB);
        rst = 1'b1;
        #1;
        check("async valid", 32'(bus.out_valid), 32'd0);
        check("async req", 32'(bus.imem_req), 32'd0);
        check("async opcode", 32'(bus.out_opcode), 32'h0);
        check("async addr", 32'(bus.imem_addr), 32'h0000);
`ifdef IFU_REDIRECT_CNT_EN
        check("redirect_cnt rst", 32'(redirect_cnt), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst req", 32'(bus.imem_req), 32'd1);
        serve(16'h0000, 16'h1123, "post_rst");
        check("post_rst opcode", 32'(bus.out_opcode), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
